// File: rtl/ctrg_pkg.sv
// Purpose: shared types and register map for the counting trigger sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrg_pkg;

    // Event bundle exchanged with the event crossbar. The bit order places
    // swt at bit 1, so a software write of 0x2 to the control register
    // emits a swt pulse.
    typedef struct packed {
        logic rst;  // bit 3
        logic stp;  // bit 2
        logic swt;  // bit 1
        logic str;  // bit 0
    } evn_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        ARMED = 2'd2,
        POST  = 2'd3
    } ctrg_sts_t;

    // Register offsets, decoded on addr[5:0].
    localparam logic [5:0] REG_CTL  = 6'h00;
    localparam logic [5:0] REG_EVN  = 6'h04;
    localparam logic [5:0] REG_MSK  = 6'h08;
    localparam logic [5:0] REG_POL  = 6'h0C;
    localparam logic [5:0] REG_MOD  = 6'h10;
    localparam logic [5:0] REG_PRE  = 6'h14;
    localparam logic [5:0] REG_PST  = 6'h18;
    localparam logic [5:0] REG_CNT  = 6'h1C;
    localparam logic [5:0] REG_SPRE = 6'h20;
    localparam logic [5:0] REG_SPST = 6'h24;

    // cfg_mod bit positions.
    localparam int MOD_AND = 0;
    localparam int MOD_ARM = 1;

    // Status events derived from the sequencer state.
    function automatic evn_t status_evs(input ctrg_sts_t s);
        evn_t e;
        e     = '0;
        e.str = (s != IDLE);
        e.stp = (s == IDLE);
        return e;
    endfunction

endpackage

// File: rtl/ctrg_seq_if.sv
// Purpose: simple register bus (clock, reset, write/read strobes, registered ack).
// Latency: slave answers with ack and rdata one cycle after wen or ren.
// Backpressure: none; every access is accepted and acknowledged.
// Ports: clk, rstn (interface ports); addr, wdata, wen, ren from master;
//        rdata, ack, err from slave.
interface sys_bus_if (
    input logic clk,
    input logic rstn
);
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport m (
        input  clk, rstn, rdata, ack, err,
        output addr, wdata, wen, ren
    );

    modport s (
        input  clk, rstn, addr, wdata, wen, ren,
        output rdata, ack, err
    );
endinterface

// File: rtl/ctrg_edg.sv
// Purpose: per-channel polarity and edge detection, OR/AND combine into one hit.
// Latency: hit is combinational from trg (one flop of history per channel).
// Backpressure: none.
// Ports: clk, rst_n; trg, msk, pol (TN wide); and_mode; hit output.
module ctrg_edg #(
    parameter int TN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TN-1:0] trg,
    input  logic [TN-1:0] msk,
    input  logic [TN-1:0] pol,
    input  logic          and_mode,
    output logic          hit
);

    logic [TN-1:0] trg_d;
    logic [TN-1:0] lvl;
    logic [TN-1:0] edg;
    logic          cnd;
    logic          cnd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trg_d <= '0;
            cnd_d <= 1'b0;
        end else begin
            trg_d <= trg;
            cnd_d <= cnd;
        end
    end

    // Polarity is applied to both the current and the delayed sample, so an
    // active edge is "now active, previously inactive" for either polarity.
    assign lvl = trg ^ pol;
    assign edg = lvl & ~(trg_d ^ pol);

    // AND condition: every enabled channel active; an empty mask never fires.
    assign cnd = (&(lvl | ~msk)) & (|msk);

    assign hit = and_mode ? (cnd & ~cnd_d) : (|(edg & msk));

endmodule

// File: rtl/ctrg_seq.sv
// Purpose: event-started trigger sequencer with pre-arm delay, post countdown, re-arm.
// Latency: trg edge at cycle n gives tro/evo.swt at n+1; event select adds one cycle.
// Backpressure: none; bus accesses always acknowledged one cycle later.
// Ports: evi (EN events in), evo (events out), trg (TN triggers), tro (trigger
//        pulse), bus (sys_bus_if slave, carries clk and rstn).
module ctrg_seq
    import ctrg_pkg::*;
#(
    parameter int CW = 32,
    parameter int ER = 0,
    parameter int EN = 1,
    parameter int EL = (EN > 1) ? $clog2(EN) : 1,
    parameter int TN = 4
) (
    input  evn_t          evi [EN],
    output evn_t          evo,
    input  logic [TN-1:0] trg,
    output logic          tro,
    sys_bus_if.s          bus
);

    logic       clk;
    logic       rst_n;
    logic [5:0] reg_addr;
    logic       unused_addr;

    assign clk         = bus.clk;
    assign rst_n       = bus.rstn;
    assign reg_addr    = bus.addr[5:0];
    assign unused_addr = &{1'b0, bus.addr[31:6]};

    // Configuration
    logic [EL-1:0] cfg_evn;
    logic [TN-1:0] cfg_msk;
    logic [TN-1:0] cfg_pol;
    logic [1:0]    cfg_mod;
    logic [CW-1:0] cfg_pre;
    logic [CW-1:0] cfg_pst;

    // Sequencer state and status counters
    ctrg_sts_t     state, state_nxt;
    logic [CW-1:0] sts_cnt, cnt_nxt;
    logic [CW-1:0] sts_pre, pre_nxt;
    logic [CW-1:0] sts_pst, pst_nxt;

    evn_t        evn_sel, evn, evs, sw_evn, int_evn;
    logic        hit, hit_t;
    logic        trig_pulse, stop_pulse;
    logic [31:0] rd_mux;

    // Event select; an out-of-range selection yields no events.
    always_comb begin
        evn_sel = '0;
        for (int i = 0; i < EN; i++) begin
            if (cfg_evn == EL'(i)) evn_sel = evi[i];
        end
    end

    ctrg_edg #(.TN(TN)) u_edg (
        .clk      (clk),
        .rst_n    (rst_n),
        .trg      (trg),
        .msk      (cfg_msk),
        .pol      (cfg_pol),
        .and_mode (cfg_mod[MOD_AND]),
        .hit      (hit)
    );

    // A swt event on the selected input acts as a forced hit.
    assign hit_t = hit | evn.swt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sts_cnt <= '0;
            sts_pre <= '0;
            sts_pst <= '0;
            evn     <= '0;
            tro     <= 1'b0;
            evo     <= '0;
        end else begin
            state   <= state_nxt;
            sts_cnt <= cnt_nxt;
            sts_pre <= pre_nxt;
            sts_pst <= pst_nxt;
            evn     <= evn_sel;
            tro     <= trig_pulse;
            evo     <= sw_evn | int_evn;
        end
    end

    // Next state. Incoming rst beats stp beats str beats a hit; the PRE and
    // POST counters hold their terminal value once they match.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = sts_cnt;
        pre_nxt    = sts_pre;
        pst_nxt    = sts_pst;
        trig_pulse = 1'b0;
        stop_pulse = 1'b0;
        if (evn.rst) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pre_nxt   = '0;
            pst_nxt   = '0;
        end else if (evn.stp) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (evn.str) begin
                        state_nxt = PRE;
                        pre_nxt   = '0;
                    end
                end
                PRE: begin
                    if (sts_pre == cfg_pre) state_nxt = ARMED;
                    else                    pre_nxt   = sts_pre + CW'(1);
                end
                ARMED: begin
                    if (hit_t) begin
                        state_nxt  = POST;
                        pst_nxt    = '0;
                        cnt_nxt    = sts_cnt + CW'(1);
                        trig_pulse = 1'b1;
                    end
                end
                POST: begin
                    if (sts_pst == cfg_pst) begin
                        if (cfg_mod[MOD_ARM]) begin
                            state_nxt = PRE;
                            pre_nxt   = '0;
                        end else begin
                            state_nxt  = IDLE;
                            stop_pulse = 1'b1;
                        end
                    end else begin
                        pst_nxt = sts_pst + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        int_evn     = '0;
        int_evn.swt = trig_pulse;
        int_evn.stp = stop_pulse;
        sw_evn      = (bus.wen && reg_addr == REG_CTL) ? evn_t'(bus.wdata[3:0]) : '0;
        evs         = status_evs(state);
    end

    // Configuration writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_evn <= EL'(ER);
            cfg_msk <= '0;
            cfg_pol <= '0;
            cfg_mod <= '0;
            cfg_pre <= '0;
            cfg_pst <= '0;
        end else if (bus.wen) begin
            case (reg_addr)
                REG_EVN: cfg_evn <= bus.wdata[EL-1:0];
                REG_MSK: cfg_msk <= bus.wdata[TN-1:0];
                REG_POL: cfg_pol <= bus.wdata[TN-1:0];
                REG_MOD: cfg_mod <= bus.wdata[1:0];
                REG_PRE: cfg_pre <= bus.wdata[CW-1:0];
                REG_PST: cfg_pst <= bus.wdata[CW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_CTL:  rd_mux = {26'd0, state, evs};
            REG_EVN:  rd_mux = 32'(cfg_evn);
            REG_MSK:  rd_mux = 32'(cfg_msk);
            REG_POL:  rd_mux = 32'(cfg_pol);
            REG_MOD:  rd_mux = 32'(cfg_mod);
            REG_PRE:  rd_mux = 32'(cfg_pre);
            REG_PST:  rd_mux = 32'(cfg_pst);
            REG_CNT:  rd_mux = 32'(sts_cnt);
            REG_SPRE: rd_mux = 32'(sts_pre);
            REG_SPST: rd_mux = 32'(sts_pst);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack <= bus.wen | bus.ren;
            if (bus.ren) bus.rdata <= rd_mux;
        end
    end

    assign bus.err = 1'b0;

endmodule

// File: tb/tb_ctrg_seq.sv
// Purpose: self-checking bench for ctrg_seq against a countdown-style event model.
// Latency: outputs compared on every falling edge against the model's prediction.
// Backpressure: none exercised; every bus access expects ack one cycle later.
module tb_ctrg_seq;
    import ctrg_pkg::*;

    localparam int TN = 4;
    localparam logic [3:0] EV_STR = 4'b0001;
    localparam logic [3:0] EV_SWT = 4'b0010;
    localparam logic [3:0] EV_STP = 4'b0100;
    localparam logic [3:0] EV_RST = 4'b1000;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    evn_t          evi [1];
    evn_t          evo;
    logic [TN-1:0] trg;
    logic          tro;

    sys_bus_if bus (.clk(clk), .rstn(rstn));

    ctrg_seq #(.CW(32), .ER(0), .EN(1), .TN(TN)) dut (
        .evi (evi),
        .evo (evo),
        .trg (trg),
        .tro (tro),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_tro  = 0;
    int n_stp  = 0;
    int last_tro = 0;
    int last_stp = 0;

    // ---------------- behavioural model ----------------
    // Phase 0..3 = idle, pre, armed, post. PRE/POST are modelled as a
    // countdown of remaining cycles loaded from the configured length.
    int            m_ph, m_left, m_cnt;
    logic [3:0]    m_evn;
    logic [TN-1:0] m_trg_d;
    logic          m_c_d;
    logic          x_tro;
    logic [3:0]    x_evo;
    logic [31:0]   s_evn, s_msk, s_pol, s_mod, s_pre, s_pst;
    logic          c_now, or_hit, hit_m, lv;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ph = 0; m_left = 0; m_cnt = 0; m_evn = '0; m_trg_d = '0; m_c_d = 1'b0;
            x_tro = 1'b0; x_evo = '0;
            s_evn = 0; s_msk = 0; s_pol = 0; s_mod = 0; s_pre = 0; s_pst = 0;
        end else begin
            c_now  = (s_msk[TN-1:0] != '0);
            or_hit = 1'b0;
            for (int i = 0; i < TN; i++) begin
                lv = trg[i] ^ s_pol[i];
                if (s_msk[i] && !lv) c_now = 1'b0;
                if (s_msk[i] && lv && !(m_trg_d[i] ^ s_pol[i])) or_hit = 1'b1;
            end
            hit_m = (s_mod[0] ? (c_now && !m_c_d) : or_hit) || m_evn[1];
            x_tro = 1'b0;
            x_evo = '0;
            if (m_evn[3]) begin
                m_ph = 0; m_cnt = 0;
            end else if (m_evn[2]) begin
                m_ph = 0;
            end else begin
                case (m_ph)
                    0: if (m_evn[0]) begin m_ph = 1; m_left = int'(s_pre); end
                    1: if (m_left == 0) m_ph = 2; else m_left--;
                    2: if (hit_m) begin
                           m_ph = 3; m_left = int'(s_pst); m_cnt++;
                           x_tro = 1'b1; x_evo = x_evo | EV_SWT;
                       end
                    default: if (m_left == 0) begin
                           if (s_mod[1]) begin m_ph = 1; m_left = int'(s_pre); end
                           else begin m_ph = 0; x_evo = x_evo | EV_STP; end
                       end else m_left--;
                endcase
            end
            if (bus.wen && bus.addr[5:0] == 6'h00) x_evo = x_evo | bus.wdata[3:0];
            m_evn   = (s_evn == 0) ? evi[0] : 4'h0;
            m_trg_d = trg;
            m_c_d   = c_now;
            if (bus.wen) begin
                case (bus.addr[5:0])
                    6'h04: s_evn = {31'd0, bus.wdata[0]};
                    6'h08: s_msk = {28'd0, bus.wdata[3:0]};
                    6'h0C: s_pol = {28'd0, bus.wdata[3:0]};
                    6'h10: s_mod = {30'd0, bus.wdata[1:0]};
                    6'h14: s_pre = bus.wdata;
                    6'h18: s_pst = bus.wdata;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Advance one cycle and compare outputs with the model on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tro === 1'b1) begin n_tro++; last_tro = cyc; end
        if (evo.stp === 1'b1) begin n_stp++; last_stp = cyc; end
        check("tro_vs_model", {31'd0, tro}, {31'd0, x_tro});
        check("evo_vs_model", {28'd0, evo}, {28'd0, x_evo});
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.wen = 1'b1;
        tick();
        bus.wen = 1'b0;
        check("wr_ack", {31'd0, bus.ack}, 32'd1);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a; bus.ren = 1'b1;
        tick();
        bus.ren = 1'b0;
        check("rd_ack", {31'd0, bus.ack}, 32'd1);
        d = bus.rdata;
    endtask

    task automatic send_evn(input logic [3:0] e);
        evi[0] = evn_t'(e);
        tick();
        evi[0] = '0;
    endtask

    logic [31:0] rd;
    int          t0, s0;

    initial begin
        evi[0] = '0; trg = '0;
        bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.ren = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset values
        bus_rd(32'h00, rd); check("rst_ctl", rd, 32'h04);
        bus_rd(32'h04, rd); check("rst_evn", rd, 32'h0);
        for (int a = 8; a <= 36; a += 4) begin
            bus_rd(32'(a), rd); check("rst_reg", rd, 32'h0);
        end
        bus_rd(32'h3C, rd); check("unmapped", rd, 32'h0);

        // OR mode, pre=3, pst=5: edge during PRE ignored, edge in ARMED fires
        bus_wr(32'h08, 32'h1);
        bus_wr(32'h0C, 32'h0);
        bus_wr(32'h10, 32'h0);
        bus_wr(32'h14, 32'd3);
        bus_wr(32'h18, 32'd5);
        t0 = n_tro; s0 = n_stp;
        send_evn(EV_STR);
        tick(); tick();
        trg = 4'b0001; tick(); tick();
        trg = 4'b0000; repeat (3) tick();
        trg = 4'b0001; repeat (12) tick();
        trg = 4'b0000; tick();
        check("or_tro_count", n_tro - t0, 1);
        check("or_stp_count", n_stp - s0, 1);
        check("or_stp_delay", last_stp - last_tro, 6);
        bus_rd(32'h1C, rd); check("or_cnt", rd, 32'd1);
        bus_rd(32'h00, rd); check("or_idle", rd, 32'h04);
        check("model_cnt1", m_cnt, 1);

        // AND mode with inverted channel 1, auto re-arm
        bus_wr(32'h0C, 32'h2);
        bus_wr(32'h08, 32'h3);
        bus_wr(32'h10, 32'h3);
        bus_wr(32'h14, 32'd0);
        bus_wr(32'h18, 32'd0);
        send_evn(EV_STR);
        repeat (4) tick();
        t0 = n_tro; s0 = n_stp;
        trg = 4'b0001; tick();
        check("and_tro_lat", {31'd0, tro}, 32'd1);
        repeat (7) tick();
        check("and_hold", n_tro - t0, 1);
        trg = 4'b0011; repeat (2) tick();
        trg = 4'b0001; repeat (4) tick();
        check("and_again", n_tro - t0, 2);
        check("and_no_stp", n_stp - s0, 0);
        send_evn(EV_STP);
        trg = 4'b0000; repeat (2) tick();
        bus_rd(32'h00, rd); check("and_idle", rd, 32'h04);

        // Auto re-arm OR mode, pre=0 pst=0, trg[0] toggling every 4 cycles
        bus_wr(32'h08, 32'h1);
        bus_wr(32'h0C, 32'h0);
        bus_wr(32'h10, 32'h2);
        send_evn(EV_STR);
        repeat (4) tick();
        t0 = n_tro; s0 = n_stp;
        for (int i = 0; i < 40; i++) begin
            trg = ((i / 4) % 2 == 1) ? 4'b0001 : 4'b0000;
            tick();
        end
        trg = 4'b0000; repeat (4) tick();
        check("arm_tro_count", n_tro - t0, 5);
        check("arm_no_stp", n_stp - s0, 0);
        bus_rd(32'h00, rd); check("arm_state", rd, 32'h21);
        send_evn(EV_STP);
        repeat (2) tick();
        bus_rd(32'h1C, rd); check("arm_cnt", rd, 32'd8);
        check("model_cnt8", m_cnt, 8);

        // str + stp + swt together while ARMED: stop wins, no trigger
        bus_wr(32'h10, 32'h0);
        send_evn(EV_STR);
        repeat (4) tick();
        t0 = n_tro;
        send_evn(EV_STR | EV_STP | EV_SWT);
        repeat (4) tick();
        check("prio_no_tro", n_tro - t0, 0);
        bus_rd(32'h00, rd); check("prio_idle", rd, 32'h04);

        // rst event during POST clears counters, no stop event
        bus_wr(32'h18, 32'd20);
        send_evn(EV_STR);
        repeat (4) tick();
        trg = 4'b0001; repeat (3) tick();
        trg = 4'b0000;
        bus_rd(32'h1C, rd); check("post_cnt", rd, 32'd9);
        bus_rd(32'h00, rd); check("post_state", rd, 32'h31);
        s0 = n_stp;
        send_evn(EV_RST);
        repeat (30) tick();
        check("rst_no_stp", n_stp - s0, 0);
        bus_rd(32'h1C, rd); check("rst_cnt", rd, 32'd0);
        bus_rd(32'h00, rd); check("rst_idle", rd, 32'h04);

        // Asynchronous reset while the trigger pulse is high
        send_evn(EV_STR);
        repeat (4) tick();
        trg = 4'b0001;
        for (int k = 0; k < 10 && tro !== 1'b1; k++) tick();
        check("tro_before_arst", {31'd0, tro}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_tro", {31'd0, tro}, 32'd0);
        check("arst_evo", {28'd0, evo}, 32'd0);
        tick(); tick();
        trg = 4'b0000;
        rstn = 1'b1;
        tick();
        bus_rd(32'h00, rd); check("arst_idle", rd, 32'h04);
        bus_rd(32'h08, rd); check("arst_msk", rd, 32'h0);
        bus_rd(32'h1C, rd); check("arst_cnt", rd, 32'h0);

        // Software swt pulse via control register
        bus_wr(32'h00, 32'h2);
        check("sw_swt", {28'd0, evo}, 32'h2);
        tick();
        check("sw_swt_end", {28'd0, evo}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrg_seq.md
Name: ctrg_seq

Overview:
- Parametrised successor to the single-shot event-counting trigger.
- Adds per-input polarity, OR/AND combine modes and a pre-trigger arming delay.
- Adds post-trigger countdown, auto re-arm, and generation of trigger/stop events for downstream acquisition blocks.
- Sits between the event crossbar (evn_pkg::evn_t) and the scope/generator channels; configured over sys_bus_if.

Parameters:
CW, 32, width of pre/post/trigger counters
ER, 0, reset value of event select
EN, 1, number of event inputs
EL, max(1,$clog2(EN)), event select width
TN, 4, number of trigger inputs

Ports:
bus.clk  input  1  sole clock (sys_bus_if member)
bus.rstn  input  1  asynchronous active-low reset (sys_bus_if member)
evi  input  EN x evn_t  event inputs
evo  output  evn_t  generated events, registered
trg  input  TN  trigger inputs, synchronous to bus.clk
tro  output  1  trigger pulse, registered
bus  sys_bus_if.s  register access

Behaviour:
- Clocking and reset: single clock. All flops reset asynchronously on bus.rstn=0.
- Reset values: evo=0, tro=0, ack=0, err=0, state=IDLE, all counters 0, cfg_evn=ER, other cfg 0.
- Bus handshake: ack registered one cycle after wen|ren; err always 0; rdata registered; unmapped reads return 0.
- Register map, addr[5:0]:
  - 00 W: evo software pulse. R: [3:0]=evs, [5:4]=state.
  - 04 cfg_evn.
  - 08 cfg_msk[TN].
  - 0C cfg_pol[TN]; 1=falling/low active.
  - 10 cfg_mod: bit0 AND mode, bit1 auto re-arm.
  - 14 cfg_pre.
  - 18 cfg_pst.
  - 1C sts_cnt.
  - 20 sts_pre.
  - 24 sts_pst.
- Config writes take effect the next cycle, also mid-run; comparisons use live values.
- Event input: evn <= evi[cfg_evn], registered; 1 cycle latency.
- Input detection, per channel:
  - trg_d <= trg.
  - lvl = trg ^ pol.
  - edg = lvl & ~(trg_d ^ pol).
- Combine, giving condition hit:
  - OR mode: hit = |(edg & msk).
  - AND mode: c = &(lvl | ~msk) & |msk; hit = c & ~c_d (rising edge of c).
  - msk=0 gives hit=0 in both modes.
  - Final: hit_t = hit | evn.swt.
- FSM states: IDLE=0, PRE=1, ARMED=2, POST=3.
  - IDLE: evn.str -> PRE, sts_pre=0.
  - PRE: sts_pre++ each cycle; when sts_pre==cfg_pre -> ARMED. cfg_pre=0 gives ARMED on the next cycle. hit_t is ignored in PRE.
  - ARMED: hit_t -> POST; tro=1 for one cycle; evo.swt=1 for that cycle; sts_cnt++ (wraps mod 2^CW); sts_pst=0.
  - POST: sts_pst++; when sts_pst==cfg_pst:
    - auto re-arm=0: evo.stp pulse, go IDLE.
    - auto re-arm=1: go PRE with sts_pre=0, no stp.
    - cfg_pst=0 completes on the cycle after the trigger.
- Event priority, per cycle: evn.rst > evn.stp > evn.str > hit_t.
  - rst: go IDLE; clear sts_cnt, sts_pre, sts_pst; no events emitted.
  - stp: go IDLE from any state; counters kept; no evo.stp emitted.
  - str while not IDLE: ignored.
- Status: evs.str = (state!=IDLE), evs.stp = (state==IDLE), evs.swt=0, evs.rst=0.
- evo is the registered OR of the software write value (00 W) and the internal pulses; each bit is a 1-cycle pulse.
- Latency: trg edge at cycle n -> tro and evo.swt at n+1.
- Reset mid-run: immediate IDLE; outputs 0 asynchronously.

Decomposition:
- ctrg_pkg holds:
  - state enum ctrg_sts_t (IDLE, PRE, ARMED, POST).
  - register offset localparams.
  - cfg_mod bit index constants.
- Sub-module ctrg_edg (TN-wide polarity/edge/AND-OR combine, outputs hit) is natural. FSM, counters and bus logic stay in ctrg_seq.

Test Plan:
- Reset then read all registers -> cfg_evn=ER; all others 0; 00 reads state=0, evs.stp=1.
- msk=0001, pol=0, OR, pre=3, pst=5, str event; trg[0] rises 2 cycles after PRE entry and again after ARMED -> first edge ignored; tro once; evo.stp exactly 6 cycles after tro; sts_cnt=1; state IDLE.
- AND mode, msk=0011, pol=0010: drive trg[0]=1 with trg[1]=0 -> tro only on the cycle after both conditions are first true; holding them gives no second tro.
- Auto re-arm, pre=0, pst=0, trg[0] toggling every 4 cycles for 40 cycles -> tro per accepted edge, no evo.stp, sts_cnt matches the tro count.
- In ARMED, evn.str, evn.stp and hit_t in the same cycle -> IDLE, no tro. evn.rst during POST with sts_cnt=7 -> sts_cnt=0, no evo.stp.
- Deassert bus.rstn asynchronously mid-POST -> tro/evo 0 immediately, state IDLE. Write 0x00=0x2 (swt) -> evo.swt pulse 1 cycle after wen; ack each access 1 cycle later.
